// File: rtl/reg_dump_pkg.sv
// Shared defaults and state encoding for the register-dump streamer.
package reg_dump_pkg;

  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned IDXW_DEF  = 5;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

endpackage

// File: rtl/reg_dump_next_idx.sv
// Priority-find of the lowest nonzero register slot at or above 'start'.
// Used by reg_dump_streamer only when REG_DUMP_SKIP_ZERO_EN is defined.
module reg_dump_next_idx
  import reg_dump_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned IDXW  = IDXW_DEF
) (
  input  logic [NREGS*XLEN-1:0] data,
  input  logic [IDXW:0]         start,
  output logic                  found,
  output logic [IDXW-1:0]       found_idx
);

  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (!found && ((IDXW+1)'(i) >= start) && (data[XLEN*i +: XLEN] != '0)) begin
        found     = 1'b1;
        found_idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/reg_dump_streamer.sv
// Snapshots the flat reg_dump bus on request and streams (index, value) beats.
// Optional macro REG_DUMP_SKIP_ZERO_EN: skip zero-valued entries.
module reg_dump_streamer
  import reg_dump_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned IDXW  = IDXW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREGS*XLEN-1:0] reg_dump,
  input  logic                  dump_req,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDXW-1:0]       out_idx,
  output logic [XLEN-1:0]       out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  state_t                  state, state_next;
  logic [IDXW-1:0]         idx, idx_next;
  logic [NREGS*XLEN-1:0]   snap;
  logic                    load;
  logic                    done_next;
  logic [IDXW:0]           idx_inc;
  logic                    first_found, nxt_found;
  logic [IDXW-1:0]         first_idx, nxt_idx;

  assign idx_inc = {1'b0, idx} + (IDXW+1)'(1);

`ifdef REG_DUMP_SKIP_ZERO_EN
  // First beat is found on the live bus, since the snapshot loads on the same edge.
  reg_dump_next_idx #(.NREGS(NREGS), .XLEN(XLEN), .IDXW(IDXW)) u_first (
    .data      (reg_dump),
    .start     ('0),
    .found     (first_found),
    .found_idx (first_idx)
  );

  reg_dump_next_idx #(.NREGS(NREGS), .XLEN(XLEN), .IDXW(IDXW)) u_next (
    .data      (snap),
    .start     (idx_inc),
    .found     (nxt_found),
    .found_idx (nxt_idx)
  );
`else
  assign first_found = 1'b1;
  assign first_idx   = '0;
  assign nxt_found   = idx_inc < (IDXW+1)'(NREGS);
  assign nxt_idx     = idx_inc[IDXW-1:0];
`endif

  assign busy      = (state == ST_STREAM);
  assign out_valid = busy;
  assign out_idx   = idx;
  assign out_data  = snap[int'(idx)*XLEN +: XLEN];
  assign out_last  = busy && !nxt_found;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dump_req) begin
          load = 1'b1;
          if (first_found) begin
            state_next = ST_STREAM;
            idx_next   = first_idx;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (!nxt_found) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            idx_next = nxt_idx;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      snap  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      done  <= done_next;
      if (load) snap <= reg_dump;
    end
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Randomized bench for reg_dump_streamer against a queue-based beat model.
module tb_reg_dump_streamer;

  localparam int NR = 32;
  localparam int XL = 32;
  localparam int IW = 5;
`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
  localparam int BASE = 1;
`else
  localparam bit SKIP = 1'b0;
  localparam int BASE = 0;
`endif
  localparam int NB = NR - BASE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR*XL-1:0] reg_dump;
  logic             dump_req = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [IW-1:0]    out_idx;
  logic [XL-1:0]    out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  logic [XL-1:0] regs [NR];

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [XL-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];
  bit    exp_done = 1'b0;
  bit    started = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) reg_dump[i*XL +: XL] = regs[i];
  end

  reg_dump_streamer #(.NREGS(NR), .XLEN(XL), .IDXW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_dump  (reg_dump),
    .dump_req  (dump_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name, input int budget);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no event within %0d cycles", name, budget);
  endtask

  // Model: a dump is the list of entries to emit; one leaves per accepted beat.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else if (exp_q.size() != 0) begin
      exp_done = 1'b0;
      if (out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) exp_done = 1'b1;
      end
    end else begin
      exp_done = 1'b0;
      if (dump_req) begin
        for (int i = 0; i < NR; i++)
          if (!SKIP || regs[i] != 0) exp_q.push_back('{idx: IW'(i), data: regs[i], last: 1'b0});
        if (exp_q.size() == 0) exp_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (started) begin
      ev = (exp_q.size() != 0);
      check("out_valid", out_valid, ev);
      check("busy", busy, ev);
      check("done", done, exp_done);
      if (ev) begin
        check("out_idx", out_idx, exp_q[0].idx);
        check("out_data", out_data, exp_q[0].data);
        check("out_last", out_last, exp_q.size() == 1);
      end else begin
        check("out_last idle", out_last, 1'b0);
      end
      if (out_valid && out_ready) log_q.push_back('{idx: out_idx, data: out_data, last: out_last});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input bit rnd, output int cycles);
    cycles = 0;
    while (!done) begin
      if (cycles >= budget) begin
        timeout_fail("run_to_done", budget);
        return;
      end
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step();
      cycles++;
    end
  endtask

  task automatic wait_idx(input int k, input int budget);
    int c;
    c = 0;
    while (!(out_valid && out_idx == IW'(k))) begin
      if (c >= budget) begin
        timeout_fail("wait_idx", budget);
        return;
      end
      step();
      c++;
    end
  endtask

  task automatic check_stride3_log(input string name);
    check({name, " beats"}, log_q.size(), NB);
    foreach (log_q[k]) begin
      check({name, " idx"}, log_q[k].idx, k + BASE);
      check({name, " data"}, log_q[k].data, (k + BASE) * 3);
      check({name, " last"}, log_q[k].last, k == NB - 1);
    end
  endtask

  initial begin
    int cyc;
    int hit;
    foreach (regs[i]) regs[i] = '0;

    rst = 1'b1;
    step();
    step();
    started = 1'b1;
    check("rst out_valid", out_valid, 0);
    check("rst out_idx", out_idx, 0);
    check("rst out_data", out_data, 0);
    check("rst out_last", out_last, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    rst = 1'b0;
    step();

    // Full-rate dump of slice i = 3*i
    foreach (regs[i]) regs[i] = XL'(i * 3);
    out_ready = 1'b1;
    log_q.delete();
    pulse_req();
    check("req latency valid", out_valid, 1);
    check("first idx", out_idx, BASE);
    run_to_done(80, 1'b0, cyc);
    check("full cycles to done", cyc, NB);
    check_stride3_log("full");

    // Snapshot isolation: x5 changes two cycles after the request
    log_q.delete();
    pulse_req();
    step();
    regs[5] = 999;
    run_to_done(80, 1'b0, cyc);
    hit = 0;
    foreach (log_q[k]) if (log_q[k].idx == 5) begin
      hit++;
      check("isolation x5", log_q[k].data, 15);
    end
    check("isolation x5 seen once", hit, 1);
    regs[5] = 15;
    step();

    // Random backpressure, same stride-3 image
    log_q.delete();
    out_ready = 1'($urandom_range(0, 1));
    pulse_req();
    run_to_done(600, 1'b1, cyc);
    check_stride3_log("bp");

    // Request during stream is ignored; request in the done cycle starts a new dump
    out_ready = 1'b1;
    step();
    log_q.delete();
    pulse_req();
    wait_idx(7, 40);
    pulse_req();
    run_to_done(80, 1'b0, cyc);
    check("ignore beats", log_q.size(), NB);
    pulse_req();
    check("done-cycle req valid", out_valid, 1);
    check("done-cycle req idx", out_idx, BASE);
    run_to_done(80, 1'b0, cyc);
    check("two dumps beats", log_q.size(), 2 * NB);

    // Reset mid-stream
    step();
    pulse_req();
    wait_idx(10, 40);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst out_valid", out_valid, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst out_idx", out_idx, 0);
    check("midrst out_data", out_data, 0);
    step();
    pulse_req();
    check("restart valid", out_valid, 1);
    check("restart idx", out_idx, BASE);
    run_to_done(80, 1'b0, cyc);

`ifdef REG_DUMP_SKIP_ZERO_EN
    step();
    foreach (regs[i]) regs[i] = '0;
    regs[1] = 5;
    regs[9] = 7;
    regs[31] = 1;
    log_q.delete();
    pulse_req();
    run_to_done(40, 1'b0, cyc);
    check("skip beats", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("skip b0", {log_q[0].idx, log_q[0].data, log_q[0].last}, {5'd1, 32'd5, 1'b0});
      check("skip b1", {log_q[1].idx, log_q[1].data, log_q[1].last}, {5'd9, 32'd7, 1'b0});
      check("skip b2", {log_q[2].idx, log_q[2].data, log_q[2].last}, {5'd31, 32'd1, 1'b1});
    end
    step();
    foreach (regs[i]) regs[i] = '0;
    pulse_req();
    check("allzero done", done, 1);
    check("allzero valid", out_valid, 0);
`endif

    // Randomized dumps with random data, stalls, stray requests and bus churn
    for (int d = 0; d < 8; d++) begin
      step();
      foreach (regs[i]) regs[i] = ($urandom_range(0, 3) == 0) ? '0 : XL'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      pulse_req();
      cyc = 0;
      while (!done && cyc < 600) begin
        out_ready = 1'($urandom_range(0, 1));
        dump_req = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, NR - 1)] = XL'($urandom);
        step();
        cyc++;
      end
      dump_req = 1'b0;
      if (!done) timeout_fail("random dump", 600);
    end

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
